pd_dequeue_scheduler: RTL and testbench

Weighted round-robin dequeue scheduler for the four per-class packet-descriptor queues in the PD memory controller. It watches the queues' ready flags and selects one queue per grant. It pulses that queue's ack to pop the head descriptor and presents the descriptor to the downstream cell-read engine with a valid/ready handshake. On handoff it recycles the descriptor's 10-bit pointer to the free-PD queue.

---
 rtl/pd_dequeue_scheduler.sv | 166 ++++++++++++++++
 tb/tb_pd_dequeue_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pd_dequeue_scheduler.sv
// ---------------------------------------------------------------------------
// PdDequeueScheduler (module pd_dequeue_scheduler)
//
// Weighted round-robin dequeue scheduler for the four per-class packet
// descriptor queues. Each grant pops the head descriptor of one queue
// (one-cycle ack), presents it downstream with a valid/ready handshake and,
// on handoff, recycles the descriptor's 10-bit pointer to the free-PD queue.
// A queue keeps the turn for max(weight,1) consecutive grants while it stays
// ready; otherwise the turn moves to the next ready queue in circular order.
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   sched_en     allows new grants to start (an in-flight grant always finishes)
//   weight_cfg   {w3,w2,w1,w0} descriptors per turn, 0 behaves as 1
//   pd_ptr_rdy   per-queue head-descriptor-valid flags
//   pd_ptr_dout  {q3,q2,q1,q0} head descriptors
//   pd_ptr_ack   one-hot, one-cycle registered pop pulse
//   out_valid    descriptor available downstream
//   out_ready    downstream accepts the descriptor
//   out_pd       granted descriptor, held stable while out_valid
//   out_qid      source queue of out_pd
//   pd_FQ_wr     one-cycle free-queue write pulse after handoff
//   pd_FQ_din    {6'b0, pointer} written to the free queue
// ---------------------------------------------------------------------------
module pd_dequeue_scheduler #(
    parameter int NQ    = 4,
    parameter int PD_W  = 128,
    parameter int WGT_W = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sched_en,
    input  logic [NQ*WGT_W-1:0]   weight_cfg,
    input  logic [NQ-1:0]         pd_ptr_rdy,
    input  logic [NQ*PD_W-1:0]    pd_ptr_dout,
    output logic [NQ-1:0]         pd_ptr_ack,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PD_W-1:0]       out_pd,
    output logic [1:0]            out_qid,
    output logic                  pd_FQ_wr,
    output logic [15:0]           pd_FQ_din
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         curQ_q, curQ_d;
    logic [WGT_W-1:0]   credit_q, credit_d;
    logic [PD_W-1:0]    outPd_q, outPd_d;
    logic [1:0]         outQid_q, outQid_d;
    logic [NQ-1:0]      ack_q, ack_d;
    logic               fqWr_q, fqWr_d;
    logic [15:0]        fqDin_q, fqDin_d;

    logic [1:0]         scanSel;
    logic               keepTurn;
    logic [1:0]         selQ;
    logic [WGT_W-1:0]   selWeight;
    logic [WGT_W-1:0]   reloadCredit;

    // Circular scan for the next owner: cur+1, cur+2, cur+3 and finally cur
    // itself. The loop walks from the farthest candidate to the nearest so the
    // nearest ready queue overwrites the others and wins.
    always_comb begin
        scanSel = curQ_q;
        for (int k = NQ; k >= 1; k--) begin
            if (pd_ptr_rdy[curQ_q + 2'(k)]) begin
                scanSel = curQ_q + 2'(k);
            end
        end
    end

    // The current owner keeps the turn only while it is ready and still has
    // credit; a fresh turn loads its credit from the weight sampled right now,
    // so weight changes in mid-turn only show up at the next turn.
    always_comb begin
        keepTurn     = pd_ptr_rdy[curQ_q] && (credit_q != '0);
        selQ         = keepTurn ? curQ_q : scanSel;
        selWeight    = weight_cfg[scanSel*WGT_W +: WGT_W];
        reloadCredit = (selWeight == '0) ? '0 : selWeight - WGT_W'(1);
    end

    // Next-state and output logic: IDLE makes the decision and latches the
    // descriptor, ACK carries the pop pulse, OUT holds the descriptor until
    // downstream takes it and then schedules the free-queue write.
    always_comb begin
        state_d  = state_q;
        curQ_d   = curQ_q;
        credit_d = credit_q;
        outPd_d  = outPd_q;
        outQid_d = outQid_q;
        ack_d    = '0;
        fqWr_d   = 1'b0;
        fqDin_d  = '0;
        case (state_q)
            IDLE: begin
                if (sched_en && (|pd_ptr_rdy)) begin
                    if (keepTurn) begin
                        credit_d = credit_q - WGT_W'(1);
                    end else begin
                        curQ_d   = scanSel;
                        credit_d = reloadCredit;
                    end
                    outPd_d  = pd_ptr_dout[selQ*PD_W +: PD_W];
                    outQid_d = selQ;
                    ack_d    = NQ'(1) << selQ;
                    state_d  = ACK;
                end
            end
            ACK: begin
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    fqWr_d  = 1'b1;
                    fqDin_d = {6'b0, outPd_q[9:0]};
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any popped-but-unsent
    // descriptor without recycling it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            curQ_q   <= '0;
            credit_q <= '0;
            outPd_q  <= '0;
            outQid_q <= '0;
            ack_q    <= '0;
            fqWr_q   <= 1'b0;
            fqDin_q  <= '0;
        end else begin
            state_q  <= state_d;
            curQ_q   <= curQ_d;
            credit_q <= credit_d;
            outPd_q  <= outPd_d;
            outQid_q <= outQid_d;
            ack_q    <= ack_d;
            fqWr_q   <= fqWr_d;
            fqDin_q  <= fqDin_d;
        end
    end

    // Registered outputs; out_valid is simply "waiting in OUT".
    always_comb begin
        pd_ptr_ack = ack_q;
        out_valid  = (state_q == OUT);
        out_pd     = outPd_q;
        out_qid    = outQid_q;
        pd_FQ_wr   = fqWr_q;
        pd_FQ_din  = fqDin_q;
    end

endmodule

// File: tb/tb_pd_dequeue_scheduler.sv
// ---------------------------------------------------------------------------
// TbPdDequeueScheduler (module tb_pd_dequeue_scheduler)
//
// Self-checking bench for pd_dequeue_scheduler. A behavioural model tracks
// the turn owner and remaining credit as plain integers and predicts which
// queue each grant must pick; directed sequences and randomized traffic are
// compared against it.
// ---------------------------------------------------------------------------
module tb_pd_dequeue_scheduler;

    logic           clk;
    logic           rstn;
    logic           sched_en;
    logic [15:0]    weight_cfg;
    logic [3:0]     pd_ptr_rdy;
    logic [511:0]   pd_ptr_dout;
    logic [3:0]     pd_ptr_ack;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_pd;
    logic [1:0]     out_qid;
    logic           pd_FQ_wr;
    logic [15:0]    pd_FQ_din;

    logic [127:0]   pdHead [4];

    int checks;
    int errors;
    int modelQ;
    int modelCredit;

    pd_dequeue_scheduler dut (
        .clk         (clk),
        .rstn        (rstn),
        .sched_en    (sched_en),
        .weight_cfg  (weight_cfg),
        .pd_ptr_rdy  (pd_ptr_rdy),
        .pd_ptr_dout (pd_ptr_dout),
        .pd_ptr_ack  (pd_ptr_ack),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pd      (out_pd),
        .out_qid     (out_qid),
        .pd_FQ_wr    (pd_FQ_wr),
        .pd_FQ_din   (pd_FQ_din)
    );

    assign pd_ptr_dout = {pdHead[3], pdHead[2], pdHead[1], pdHead[0]};

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomHeads();
        for (int i = 0; i < 4; i++) begin
            pdHead[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Reference rule: the owner keeps the turn while ready and in credit,
    // otherwise the first ready queue after it (wrapping back to itself)
    // takes a new turn worth max(weight,1) grants.
    task automatic modelPick(input logic [3:0] rdy, output int sel);
        int w;
        if (rdy[modelQ] && modelCredit != 0) begin
            sel = modelQ;
            modelCredit = modelCredit - 1;
        end else begin
            sel = modelQ;
            for (int k = 1; k <= 4; k++) begin
                if (rdy[(modelQ + k) % 4]) begin
                    sel = (modelQ + k) % 4;
                    break;
                end
            end
            w = (int'(weight_cfg) >> (sel * 4)) & 15;
            modelQ = sel;
            modelCredit = (w == 0) ? 0 : w - 1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ack"},   pd_ptr_ack, 0);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_pd"},    out_pd, 0);
        checkOutput({tag, "_qid"},   out_qid, 0);
        checkOutput({tag, "_fqwr"},  pd_FQ_wr, 0);
        checkOutput({tag, "_fqdin"}, pd_FQ_din, 0);
    endtask

    task automatic doReset();
        rstn       = 1'b0;
        sched_en   = 1'b0;
        pd_ptr_rdy = 4'b0;
        out_ready  = 1'b0;
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        modelQ = 0;
        modelCredit = 0;
    endtask

    // One full grant starting in IDLE just after an edge: decision, ack,
    // optional stall in OUT, handoff and free-queue write.
    task automatic applyStimulus(input logic [3:0] rdy, input int stall, input bit randHeadsEn,
                                 input bit dropEn, output int qid);
        logic [127:0] expPd;
        logic [3:0]   expAck;
        if (randHeadsEn) randomHeads();
        pd_ptr_rdy = rdy;
        sched_en   = 1'b1;
        out_ready  = 1'b0;
        modelPick(rdy, qid);
        expPd  = pdHead[qid];
        expAck = 4'b0001 << qid;
        tick();
        if (dropEn) sched_en = 1'b0;
        checkOutput("ack_pulse", pd_ptr_ack, expAck);
        checkOutput("ack_valid", out_valid, 0);
        checkOutput("ack_fqwr", pd_FQ_wr, 0);
        tick();
        checkOutput("out_ack", pd_ptr_ack, 0);
        checkOutput("out_valid", out_valid, 1);
        checkOutput("out_pd", out_pd, expPd);
        checkOutput("out_qid", out_qid, qid);
        pd_ptr_rdy = 4'($urandom);
        randomHeads();
        for (int s = 0; s < stall; s++) begin
            tick();
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_pd", out_pd, expPd);
            checkOutput("stall_qid", out_qid, qid);
            checkOutput("stall_ack", pd_ptr_ack, 0);
            checkOutput("stall_fqwr", pd_FQ_wr, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("fq_wr", pd_FQ_wr, 1);
        checkOutput("fq_din", pd_FQ_din, {6'b0, expPd[9:0]});
        checkOutput("fq_valid", out_valid, 0);
        checkOutput("fq_ack", pd_ptr_ack, 0);
    endtask

    // Cycles in IDLE where no grant may start (empty queues or disabled).
    task automatic idleCheck(input logic [3:0] rdy, input logic en, input int cycles);
        pd_ptr_rdy = rdy;
        sched_en   = en;
        for (int c = 0; c < cycles; c++) begin
            tick();
            checkOutput("idle_ack", pd_ptr_ack, 0);
            checkOutput("idle_valid", out_valid, 0);
        end
    endtask

    initial begin
        int qid;
        int seqA [7];
        int seqB [4];
        int seqC [5];
        logic [3:0] rdyC [5];
        logic [3:0] r;

        checks = 0;
        errors = 0;
        weight_cfg = 16'h0;
        for (int i = 0; i < 4; i++) pdHead[i] = '0;
        doReset();

        // Single descriptor from q0, pointer 5 recycled.
        pdHead[0] = 128'h8005;
        applyStimulus(4'b0001, 0, 1'b0, 1'b0, qid);
        checkOutput("first_qid", qid, 0);

        // Weighted order with w1=3, w2=1, w3=2, w0=1.
        doReset();
        weight_cfg = 16'h2131;
        seqA = '{1, 1, 1, 2, 3, 3, 0};
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 7; i++) begin
                applyStimulus(4'hF, 0, 1'b1, 1'b0, qid);
                checkOutput("wrr_seq", qid, seqA[i]);
            end
        end

        // Zero weights behave as one: plain round-robin.
        doReset();
        weight_cfg = 16'h0000;
        seqB = '{1, 2, 3, 0};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'hF, 0, 1'b1, 1'b0, qid);
            checkOutput("rr_seq", qid, seqB[i % 4]);
        end

        // Long downstream stall.
        applyStimulus(4'hF, 10, 1'b1, 1'b0, qid);

        // q2 (weight 4) empties after two grants; q3 (weight 2) takes over.
        doReset();
        weight_cfg = 16'h2400;
        rdyC = '{4'b0100, 4'b0100, 4'b1000, 4'b1100, 4'b1100};
        seqC = '{2, 2, 3, 3, 2};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(rdyC[i], 0, 1'b1, 1'b0, qid);
            checkOutput("drain_seq", qid, seqC[i]);
        end

        // Empty queues and disabled scheduler leave the FSM idle.
        idleCheck(4'b0000, 1'b1, 3);
        applyStimulus(4'hF, 1, 1'b1, 1'b1, qid);
        idleCheck(4'hF, 1'b0, 4);

        // Reset while a descriptor waits in OUT.
        randomHeads();
        pd_ptr_rdy = 4'hF;
        sched_en   = 1'b1;
        out_ready  = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("pre_rst_valid", out_valid, 1);
        rstn = 1'b0;
        #1;
        checkAllZero("mid_reset");
        sched_en   = 1'b0;
        pd_ptr_rdy = 4'b0;
        @(negedge clk);
        rstn = 1'b1;
        modelQ = 0;
        modelCredit = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("post_rst_fqwr", pd_FQ_wr, 0);
        end
        applyStimulus(4'hF, 0, 1'b1, 1'b0, qid);
        checkOutput("post_rst_qid", qid, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) weight_cfg = 16'($urandom);
            r = 4'($urandom_range(0, 15));
            if (r == 4'b0) begin
                idleCheck(4'b0, 1'b1, $urandom_range(1, 2));
            end else if ($urandom_range(0, 9) == 0) begin
                applyStimulus(r, $urandom_range(0, 3), 1'b1, 1'b1, qid);
                idleCheck(4'hF, 1'b0, 2);
            end else begin
                applyStimulus(r, $urandom_range(0, 3), 1'b1, 1'b0, qid);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
